cmd_out_shaper: RTL and testbench

- Output-side counterpart of the per-command input filter array: shapes NUM_SIGNALS command requests into output drive signals.
- Enforces a minimum ON time and a minimum OFF time per channel.
- Durations are counted in ticks of a shared timebase strobe.
- Sits between command logic and the output drivers/relays; one independent state machine and one counter per channel.

---
 rtl/cmd_out_shaper.sv | 185 ++++++++++++++++++
 tb/tb_cmd_out_shaper.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/cmd_out_shaper.sv
// cmd_out_shaper: per-channel output shaper enforcing minimum ON and OFF times,
// counted in ticks of a shared timebase strobe.
// Optional max-on-time lockout with sticky fault: define CMD_MAX_ON_EN.
//
// state      | meaning
// -----------+----------------------------------------------------------
// S_OFF      | output low, idle, waiting for a request
// S_ON_HOLD  | output high, minimum ON time running, request ignored
// S_ON       | output high, follows request
// S_OFF_HOLD | output low, minimum OFF time running, request ignored
// S_LOCKOUT  | output low after max-on timeout, waits for request release
module cmd_out_shaper #(
    parameter int NUM_SIGNALS   = 16,
    parameter int CNT_WIDTH     = 8,
    parameter int MIN_ON_TICKS  = 4,
    parameter int MIN_OFF_TICKS = 2,
    parameter int MAX_ON_TICKS  = 200
) (
    input  logic                   clk,
    input  logic                   aclr,
    input  logic [NUM_SIGNALS-1:0] in,
    input  logic                   tick,
    input  logic                   fault_clr,
    output logic [NUM_SIGNALS-1:0] out,
    output logic [NUM_SIGNALS-1:0] busy,
    output logic [NUM_SIGNALS-1:0] fault
);

    typedef enum logic [2:0] {
        S_OFF      = 3'd0,
        S_ON_HOLD  = 3'd1,
        S_ON       = 3'd2,
        S_OFF_HOLD = 3'd3,
        S_LOCKOUT  = 3'd4
    } state_t;

    localparam logic [CNT_WIDTH-1:0] ON_LOAD  = CNT_WIDTH'(MIN_ON_TICKS);
    localparam logic [CNT_WIDTH-1:0] OFF_LOAD = CNT_WIDTH'(MIN_OFF_TICKS);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

    state_t               state_q [NUM_SIGNALS];
    state_t               state_d [NUM_SIGNALS];
    logic [CNT_WIDTH-1:0] cnt_q   [NUM_SIGNALS];
    logic [CNT_WIDTH-1:0] cnt_d   [NUM_SIGNALS];
    logic [NUM_SIGNALS-1:0] out_d;
    logic [NUM_SIGNALS-1:0] busy_d;

`ifdef CMD_MAX_ON_EN
    localparam int OT_W = (MAX_ON_TICKS > 1) ? $clog2(MAX_ON_TICKS) : 1;
    localparam logic [OT_W-1:0] OT_LAST = OT_W'(MAX_ON_TICKS - 1);
    logic [OT_W-1:0]        ot_q [NUM_SIGNALS];
    logic [OT_W-1:0]        ot_d [NUM_SIGNALS];
    logic [NUM_SIGNALS-1:0] fault_set;
`endif

    // Next-state, counter and output decode for every channel
    always_comb begin
        out_d  = '0;
        busy_d = '0;
`ifdef CMD_MAX_ON_EN
        fault_set = '0;
`endif
        for (int i = 0; i < NUM_SIGNALS; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
`ifdef CMD_MAX_ON_EN
            ot_d[i]    = ot_q[i];
`endif
            case (state_q[i])
                S_OFF: begin
                    if (in[i]) begin
                        state_d[i] = S_ON_HOLD;
                        cnt_d[i]   = ON_LOAD;
`ifdef CMD_MAX_ON_EN
                        ot_d[i]    = '0;
`endif
                    end
                end
                S_ON_HOLD: begin
                    if (tick) begin
                        if (cnt_q[i] == CNT_ONE) begin
                            if (in[i]) begin
                                state_d[i] = S_ON;
                                cnt_d[i]   = '0;
                            end else begin
                                state_d[i] = S_OFF_HOLD;
                                cnt_d[i]   = OFF_LOAD;
                            end
                        end else begin
                            cnt_d[i] = cnt_q[i] - CNT_ONE;
                        end
                    end
                end
                S_ON: begin
                    if (!in[i]) begin
                        state_d[i] = S_OFF_HOLD;
                        cnt_d[i]   = OFF_LOAD;
                    end
                end
                S_OFF_HOLD: begin
                    if (tick) begin
                        if (cnt_q[i] == CNT_ONE) begin
                            if (in[i]) begin
                                state_d[i] = S_ON_HOLD;
                                cnt_d[i]   = ON_LOAD;
`ifdef CMD_MAX_ON_EN
                                ot_d[i]    = '0;
`endif
                            end else begin
                                state_d[i] = S_OFF;
                                cnt_d[i]   = '0;
                            end
                        end else begin
                            cnt_d[i] = cnt_q[i] - CNT_ONE;
                        end
                    end
                end
`ifdef CMD_MAX_ON_EN
                S_LOCKOUT: begin
                    if (!in[i]) begin
                        state_d[i] = S_OFF_HOLD;
                        cnt_d[i]   = OFF_LOAD;
                    end
                end
`endif
                default: begin
                    state_d[i] = S_OFF;
                    cnt_d[i]   = '0;
                end
            endcase
`ifdef CMD_MAX_ON_EN
            // Max-on timeout overrides any other transition of a high channel
            if (tick && (state_q[i] == S_ON_HOLD || state_q[i] == S_ON)) begin
                if (ot_q[i] == OT_LAST) begin
                    state_d[i]   = S_LOCKOUT;
                    cnt_d[i]     = '0;
                    fault_set[i] = 1'b1;
                end else begin
                    ot_d[i] = ot_q[i] + OT_W'(1);
                end
            end
`endif
            out_d[i]  = (state_d[i] == S_ON_HOLD) || (state_d[i] == S_ON);
            busy_d[i] = (state_d[i] != S_OFF);
        end
    end

    // State, counters and registered outputs
    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            for (int i = 0; i < NUM_SIGNALS; i++) begin
                state_q[i] <= S_OFF;
                cnt_q[i]   <= '0;
`ifdef CMD_MAX_ON_EN
                ot_q[i]    <= '0;
`endif
            end
            out  <= '0;
            busy <= '0;
        end else begin
            for (int i = 0; i < NUM_SIGNALS; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
`ifdef CMD_MAX_ON_EN
                ot_q[i]    <= ot_d[i];
`endif
            end
            out  <= out_d;
            busy <= busy_d;
        end
    end

`ifdef CMD_MAX_ON_EN
    // Sticky fault bits; a new fault wins over a simultaneous clear
    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) fault <= '0;
        else      fault <= (fault & ~{NUM_SIGNALS{fault_clr}}) | fault_set;
    end
`else
    assign fault = '0;
    logic unused_fault_clr;
    assign unused_fault_clr = fault_clr;
`endif

endmodule

// File: tb/tb_cmd_out_shaper.sv
// Scoreboard bench for cmd_out_shaper: a driver applies stimulus on the falling
// edge and queues the expected outputs of a phase/ticks-left reference model;
// a monitor pops and compares after every rising edge.
module tb_cmd_out_shaper;
    localparam int N       = 16;
    localparam int MIN_ON  = 4;
    localparam int MIN_OFF = 2;
    localparam int MAXON   = 200;
`ifdef CMD_MAX_ON_EN
    localparam bit MAXEN = 1'b1;
`else
    localparam bit MAXEN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         aclr;
    logic [N-1:0] in;
    logic         tick;
    logic         fault_clr;
    logic [N-1:0] out, busy, fault;

    cmd_out_shaper dut (
        .clk(clk), .aclr(aclr), .in(in), .tick(tick), .fault_clr(fault_clr),
        .out(out), .busy(busy), .fault(fault)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    bit mon_en = 1'b0;
    logic [3*N-1:0] exp_q[$];

    // Reference model: output level, ticks left in the current minimum phase,
    // lockout flag, ticks spent high, sticky fault.
    bit m_out[N], m_lock[N], m_fault[N];
    int m_left[N], m_on[N];

    task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s at %0t: actual=%h required=%h", name, $time, act, req);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_out[i] = 0; m_lock[i] = 0; m_fault[i] = 0; m_left[i] = 0; m_on[i] = 0;
        end
    endtask

    task automatic model_step(input logic [N-1:0] iv, input bit tk, input bit clr);
        for (int i = 0; i < N; i++) begin
            bit r;
            bit nf;
            r  = iv[i];
            nf = 0;
            if (m_lock[i]) begin
                if (!r) begin m_lock[i] = 0; m_left[i] = MIN_OFF; end
            end else if (m_out[i]) begin
                if (MAXEN && tk && m_on[i] == MAXON - 1) begin
                    m_out[i] = 0; m_lock[i] = 1; m_left[i] = 0; nf = 1;
                end else begin
                    if (tk) m_on[i]++;
                    if (m_left[i] > 0) begin
                        if (tk) begin
                            if (m_left[i] == 1) begin
                                if (r) m_left[i] = 0;
                                else begin m_out[i] = 0; m_left[i] = MIN_OFF; end
                            end else m_left[i]--;
                        end
                    end else if (!r) begin
                        m_out[i] = 0; m_left[i] = MIN_OFF;
                    end
                end
            end else if (m_left[i] > 0) begin
                if (tk) begin
                    if (m_left[i] == 1) begin
                        m_left[i] = 0;
                        if (r) begin m_out[i] = 1; m_left[i] = MIN_ON; m_on[i] = 0; end
                    end else m_left[i]--;
                end
            end else if (r) begin
                m_out[i] = 1; m_left[i] = MIN_ON; m_on[i] = 0;
            end
            m_fault[i] = MAXEN && (nf || (m_fault[i] && !clr));
        end
    endtask

    function automatic logic [3*N-1:0] model_outputs();
        logic [N-1:0] o, b, f;
        for (int i = 0; i < N; i++) begin
            o[i] = m_out[i];
            b[i] = m_out[i] || m_lock[i] || (m_left[i] > 0);
            f[i] = m_fault[i];
        end
        return {o, b, f};
    endfunction

    task automatic apply(input logic [N-1:0] iv, input bit tk, input bit clr);
        in = iv; tick = tk; fault_clr = clr;
        model_step(iv, tk, clr);
        exp_q.push_back(model_outputs());
        mon_en = 1'b1;
    endtask

    task automatic cycle(input logic [N-1:0] iv, input bit tk, input bit clr);
        @(negedge clk);
        apply(iv, tk, clr);
    endtask

    // Asynchronous reset pulse spanning one rising edge, request held throughout
    task automatic pulse_reset(input logic [N-1:0] hold);
        @(negedge clk);
        #1;
        aclr = 1'b1;
        in   = hold;
        #1;
        check("async_out", out, '0);
        check("async_busy", busy, '0);
        check("async_fault", fault, '0);
        model_reset();
        exp_q.push_back('0);
        @(negedge clk);
        aclr = 1'b0;
        apply(hold, 1'b1, 1'b0);
    endtask

    // Monitor: compare DUT outputs with the oldest queued expectation
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (mon_en) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL scoreboard_empty at %0t: actual=none required=entry", $time);
                end else begin
                    logic [3*N-1:0] e;
                    e = exp_q.pop_front();
                    check("out", out, e[3*N-1:2*N]);
                    check("busy", busy, e[2*N-1:N]);
                    check("fault", fault, e[N-1:0]);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog at %0t: actual=running required=finished", $time);
        $fatal(1);
    end

    initial begin
        logic [N-1:0] cur;
        aclr = 1'b1; in = '0; tick = 1'b0; fault_clr = 1'b0;
        model_reset();
        #1;
        check("reset_out", out, '0);
        check("reset_busy", busy, '0);
        check("reset_fault", fault, '0);
        @(negedge clk);
        @(negedge clk);
        aclr = 1'b0;
        apply('0, 1'b1, 1'b0);

        // 1-clk pulse on channel 0, tick every clk
        cycle(16'h0001, 1'b1, 1'b0);
        repeat (10) cycle('0, 1'b1, 1'b0);
        // channel 3 held 20 clks
        repeat (20) cycle(16'h0008, 1'b1, 1'b0);
        repeat (8) cycle('0, 1'b1, 1'b0);
        // tick every 4th clk, 1-clk pulse on channel 5
        for (int k = 0; k < 40; k++) cycle((k == 3) ? 16'h0020 : 16'h0000, (k % 4) == 3, 1'b0);
        // channel 7 toggling every clk
        for (int k = 0; k < 30; k++) cycle((k % 2 == 0) ? 16'h0080 : 16'h0000, 1'b1, 1'b0);
        repeat (4) cycle('0, 1'b1, 1'b0);
        // reset mid ON_HOLD on channel 2 with request held
        repeat (2) cycle(16'h0004, 1'b1, 1'b0);
        pulse_reset(16'h0004);
        repeat (8) cycle(16'h0004, 1'b1, 1'b0);
        repeat (4) cycle('0, 1'b1, 1'b0);
        // channel 1 held 300 clks, then release and clear faults
        repeat (300) cycle(16'h0002, 1'b1, 1'b0);
        repeat (6) cycle('0, 1'b1, 1'b0);
        cycle('0, 1'b1, 1'b1);
        repeat (4) cycle('0, 1'b1, 1'b0);

        // randomized traffic with occasional resets and fault clears
        cur = '0;
        for (int k = 0; k < 2000; k++) begin
            cur ^= N'($urandom & $urandom & $urandom);
            if ((k % 500) == 250) pulse_reset(cur);
            else cycle(cur, $urandom_range(0, 2) == 0 || k < 400,
                       $urandom_range(0, 63) == 0);
        end

        @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL scoreboard_leftover: actual=%0d required=0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
